// File: rtl/dm_pkg.sv
// Shared MemOp encodings, lane constants and access-legality helper for the data memory.
// DM_HALFWORD_EN makes the halfword ops (LH/LHU/SH) legal.
package dm_pkg;

  localparam logic [2:0] DM_WORD   = 3'd0;
  localparam logic [2:0] DM_BYTE_S = 3'd1;
  localparam logic [2:0] DM_BYTE_U = 3'd2;
  localparam logic [2:0] DM_HALF_S = 3'd3;
  localparam logic [2:0] DM_HALF_U = 3'd4;

  localparam logic [1:0] DM_LANE0 = 2'd0;
  localparam logic [1:0] DM_LANE1 = 2'd1;
  localparam logic [1:0] DM_LANE2 = 2'd2;
  localparam logic [1:0] DM_LANE3 = 2'd3;

  // Opcode/alignment legality only; the address range check lives in data_mem.
  function automatic logic dm_op_legal(input logic [2:0] op, input logic [1:0] lane);
    logic ok;
    ok = 1'b0;
    case (op)
      DM_WORD:              ok = (lane == DM_LANE0);
      DM_BYTE_S, DM_BYTE_U: ok = 1'b1;
`ifdef DM_HALFWORD_EN
      DM_HALF_S, DM_HALF_U: ok = ~lane[0];
`endif
      default:              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Lane select with sign/zero extension for loads, plus the matching store byte-enables.
// Half-lane muxing exists only when DM_HALFWORD_EN is defined.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  MemOp,
  output logic [31:0] RD,
  output logic [3:0]  be
);

  logic [7:0] byte_sel;
`ifdef DM_HALFWORD_EN
  logic [15:0] half_sel;
`endif

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
`ifdef DM_HALFWORD_EN
    half_sel = lane[1] ? word[31:16] : word[15:0];
`endif
    RD = '0;
    be = '0;
    case (MemOp)
      DM_WORD: begin
        RD = word;
        be = 4'hf;
      end
      DM_BYTE_S: begin
        RD = {{24{byte_sel[7]}}, byte_sel};
        be = 4'b0001 << lane;
      end
      DM_BYTE_U: begin
        RD = {24'h0, byte_sel};
        be = 4'b0001 << lane;
      end
`ifdef DM_HALFWORD_EN
      DM_HALF_S: begin
        RD = {{16{half_sel[15]}}, half_sel};
        be = lane[1] ? 4'b1100 : 4'b0011;
      end
      DM_HALF_U: begin
        RD = {16'h0, half_sel};
        be = lane[1] ? 4'b1100 : 4'b0011;
      end
`endif
      default: begin
        RD = '0;
        be = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Single-cycle MIPS data memory: combinational loads, posedge stores, error flag and store counter.
// Define DM_HALFWORD_EN to enable LH/LHU/SH.
module data_mem
  import dm_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemWrite,
  input  logic [2:0]  MemOp,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        AddrErr,
  output logic [31:0] StoreCnt
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [32:0]   diff;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          in_range;
  logic [31:0]   rd_ext;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          we;

  // diff[32] is the borrow, i.e. Addr below ADDR_BASE.
  assign diff     = {1'b0, Addr} - {1'b0, ADDR_BASE};
  assign off      = diff[31:0];
  assign idx      = off[AW+1:2];
  assign lane     = off[1:0];
  assign in_range = ~diff[32] && ({1'b0, off} < SPAN);
  assign AddrErr  = ~in_range | ~dm_op_legal(MemOp, lane);

  dm_load_ext u_ext (
    .word  (mem[idx]),
    .lane  (lane),
    .MemOp (MemOp),
    .RD    (rd_ext),
    .be    (be)
  );

  assign RD = AddrErr ? '0 : rd_ext;
  assign we = MemWrite & ~AddrErr;

  // Replicate the store data across lanes so the byte-enables alone pick the target.
  always_comb begin
    wdata = WD;
    case (MemOp)
      DM_BYTE_S, DM_BYTE_U: wdata = {4{WD[7:0]}};
      DM_HALF_S, DM_HALF_U: wdata = {2{WD[15:0]}};
      default:              wdata = WD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
      StoreCnt <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
      StoreCnt <= StoreCnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed steps then random loads/stores against a byte-array model.
// Expectations follow DM_HALFWORD_EN the same way the design does.
module tb_data_mem;

  localparam logic [2:0] OP_WORD   = 3'd0;
  localparam logic [2:0] OP_BYTE_S = 3'd1;
  localparam logic [2:0] OP_BYTE_U = 3'd2;
  localparam logic [2:0] OP_HALF_S = 3'd3;
  localparam logic [2:0] OP_HALF_U = 3'd4;

  logic        clk;
  logic        rst_n;
  logic        MemWrite;
  logic [2:0]  MemOp;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        AddrErr;
  logic [31:0] StoreCnt;

  int total = 0;
  int bad   = 0;

  // Reference model: byte-addressed memory of 4 KiB plus a store counter.
  logic [7:0]  mb [4096];
  logic [31:0] m_cnt;

  data_mem dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .MemWrite (MemWrite),
    .MemOp    (MemOp),
    .Addr     (Addr),
    .WD       (WD),
    .RD       (RD),
    .AddrErr  (AddrErr),
    .StoreCnt (StoreCnt)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_legal(input logic [2:0] op, input logic [31:0] a);
    if (a >= 32'h1000) return 1'b0;
    case (op)
      OP_WORD:              return (a % 4) == 0;
      OP_BYTE_S, OP_BYTE_U: return 1'b1;
`ifdef DM_HALFWORD_EN
      OP_HALF_S, OP_HALF_U: return (a % 2) == 0;
`endif
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a);
    int i;
    logic [15:0] h;
    if (!m_legal(op, a)) return 32'h0;
    i = int'(a);
    h = {mb[i+1], mb[i]};
    case (op)
      OP_WORD:   return {mb[i+3], mb[i+2], mb[i+1], mb[i]};
      OP_BYTE_S: return 32'($signed(mb[i]));
      OP_BYTE_U: return {24'h0, mb[i]};
      OP_HALF_S: return 32'($signed(h));
      OP_HALF_U: return {16'h0, h};
      default:   return 32'h0;
    endcase
  endfunction

  task automatic m_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    int i;
    int n;
    if (!m_legal(op, a)) return;
    i = int'(a);
    n = (op == OP_WORD) ? 4 : (op == OP_BYTE_S || op == OP_BYTE_U) ? 1 : 2;
    for (int k = 0; k < n; k++) mb[i+k] = d[8*k +: 8];
    m_cnt = m_cnt + 32'd1;
  endtask

  task automatic m_reset();
    foreach (mb[i]) mb[i] = 8'h0;
    m_cnt = 32'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    MemWrite = 1'b0;
    MemOp    = op;
    Addr     = a;
    #1;
    check({tag, ".rd"},  RD, m_load(op, a));
    check({tag, ".err"}, 32'(AddrErr), 32'(!m_legal(op, a)));
    check({tag, ".cnt"}, StoreCnt, m_cnt);
  endtask

  task automatic do_store(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] d);
    @(negedge clk);
    MemWrite = 1'b1;
    MemOp    = op;
    Addr     = a;
    WD       = d;
    #1;
    check({tag, ".err"},    32'(AddrErr), 32'(!m_legal(op, a)));
    check({tag, ".rd_old"}, RD, m_load(op, a));
    @(posedge clk);
    m_store(op, a, d);
    #1;
    MemWrite = 1'b0;
    check({tag, ".cnt"}, StoreCnt, m_cnt);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    int          sel;

    rst_n    = 1'b0;
    MemWrite = 1'b0;
    MemOp    = OP_WORD;
    Addr     = 32'h0;
    WD       = 32'h0;
    m_reset();
    #12;
    rst_n = 1'b1;

    // 1: reset state
    do_load("rst_lw0",   OP_WORD, 32'h0);
    do_load("rst_lwffc", OP_WORD, 32'hFFC);

    // 2: word store then byte loads of the top lane
    do_store("sw10", OP_WORD, 32'h10, 32'h8765_4321);
    do_load("lw10",  OP_WORD,   32'h10);
    check("lw10.const", RD, 32'h8765_4321);
    do_load("lb13",  OP_BYTE_S, 32'h13);
    check("lb13.const", RD, 32'hFFFF_FF87);
    do_load("lbu13", OP_BYTE_U, 32'h13);
    check("lbu13.const", RD, 32'h0000_0087);

    // 3: byte store merges into the word
    do_store("sb11", OP_BYTE_U, 32'h11, 32'h0000_00AB);
    do_load("lw10b", OP_WORD, 32'h10);
    check("lw10b.const", RD, 32'h8765_AB21);

    // 4: misaligned and out-of-range word stores are dropped
    do_store("sw12",   OP_WORD, 32'h12,   32'hDEAD_BEEF);
    do_store("sw1000", OP_WORD, 32'h1000, 32'hDEAD_BEEF);
    do_load("lw10c", OP_WORD, 32'h10);
    do_load("lw1000", OP_WORD, 32'h1000);

    // 5: reset asserted mid-cycle, held across the edge
    @(negedge clk);
    MemWrite = 1'b1;
    MemOp    = OP_WORD;
    Addr     = 32'h20;
    WD       = 32'h1234_5678;
    #2;
    rst_n = 1'b0;
    m_reset();
    @(posedge clk);
    #2;
    rst_n    = 1'b1;
    MemWrite = 1'b0;
    do_load("rst_lw20", OP_WORD, 32'h20);
    check("rst_cnt.const", StoreCnt, 32'h0);
    do_load("rst_lw10", OP_WORD, 32'h10);

    // 6: halfword path (legal only with DM_HALFWORD_EN)
    do_store("sh22", OP_HALF_U, 32'h22, 32'h0000_F00D);
    do_load("lh22",  OP_HALF_S, 32'h22);
    do_load("lhu22", OP_HALF_U, 32'h22);
    do_load("lh21",  OP_HALF_S, 32'h21);
    do_load("lw20",  OP_WORD,   32'h20);
    do_store("res5", 3'd5, 32'h30, 32'hFFFF_FFFF);
    do_load("res7",  3'd7, 32'h30);
    do_load("lbfff", OP_BYTE_S, 32'hFFF);

    // random mix of loads and stores, including reserved ops and bad addresses
    for (int n = 0; n < 300; n++) begin
      op  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, 63));
      else if (sel == 7) a = 32'hFF0 + 32'($urandom_range(0, 15));
      else if (sel == 8) a = 32'h1000 + 32'($urandom_range(0, 8));
      else               a = $urandom;
      if ($urandom_range(0, 1) == 1) do_store("rnd_st", op, a, $urandom);
      else                           do_load("rnd_ld", op, a);
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
